// File: rtl/spi_master_ctrl.sv
// SPI master for 24-bit register frames (rw, addr, data), SPI mode 0.
// Half-period of SCLK is CLK_DIV system clocks; all outputs registered.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic        i_spi_master_clk,
  input  logic        i_spi_master_reset_n,
  input  logic        i_spi_master_start,
  input  logic        i_spi_master_rw,
  input  logic [12:0] i_spi_master_addr,
  input  logic [7:0]  i_spi_master_wr_data,
  output logic        o_spi_master_busy,
  output logic        o_spi_master_done,
  output logic [7:0]  o_spi_master_rd_data,
  output logic        o_spi_master_sclk,
  output logic        o_spi_master_csb_n,
  output logic        o_spi_master_sdi,
  input  logic        i_spi_master_sdo
);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP
  } state_t;

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
  localparam bit         DIV1 = (CLK_DIV == 1);
  localparam logic [7:0] PRE  =
    DIV1 ? 8'd0 : 8'(CLK_DIV - 2);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic        hi_q, hi_d;
  logic        rw_q, rw_d;
  logic [23:0] frame_q, frame_d;
  logic [7:0]  rd_sh_q, rd_sh_d;
  logic        sclk_q, sclk_d;
  logic        csb_q, csb_d;
  logic        sdi_q, sdi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        last;
  logic [7:0]  cnt_inc;

  assign last    = (cnt_q == LAST);
  assign cnt_inc = last ? 8'd0 : cnt_q + 8'd1;

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    hi_d      = hi_q;
    rw_d      = rw_q;
    frame_d   = frame_q;
    rd_sh_d   = rd_sh_q;
    sclk_d    = sclk_q;
    csb_d     = csb_q;
    sdi_d     = sdi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_spi_master_start) begin
          state_d = SETUP;
          rw_d    = i_spi_master_rw;
          frame_d = {i_spi_master_rw, 2'b00,
                     i_spi_master_addr,
                     i_spi_master_rw ? 8'h00
                       : i_spi_master_wr_data};
          csb_d   = 1'b0;
          sclk_d  = 1'b0;
          sdi_d   = i_spi_master_rw;
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
          bit_d   = 5'd0;
          hi_d    = 1'b0;
          rd_sh_d = 8'h00;
        end
      end
      SETUP: begin
        cnt_d = cnt_inc;
        if (last) state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_inc;
        if (last) begin
          if (!hi_q) begin
            hi_d   = 1'b1;
            sclk_d = 1'b1;
          end else begin
            hi_d   = 1'b0;
            sclk_d = 1'b0;
            if (rw_q && bit_q >= 5'd16)
              rd_sh_d = {rd_sh_q[6:0],
                         i_spi_master_sdo};
            if (bit_q == 5'd23) begin
              state_d = HOLD;
              sdi_d   = 1'b0;
            end else begin
              bit_d   = bit_q + 5'd1;
              frame_d = {frame_q[22:0], 1'b0};
              sdi_d   = frame_q[22];
            end
          end
        end
      end
      HOLD: begin
        cnt_d = cnt_inc;
        if (last) begin
          state_d = GAP;
          csb_d   = 1'b1;
          done_d  = DIV1;
        end
      end
      GAP: begin
        cnt_d = cnt_inc;
        if (!DIV1 && cnt_q == PRE) done_d = 1'b1;
        if (last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    rd_data_d = (done_d && rw_q) ? rd_sh_d
                                 : rd_data_q;
  end

  // State, counters and registered SPI/status outputs.
  always_ff @(posedge i_spi_master_clk or
              negedge i_spi_master_reset_n) begin
    if (!i_spi_master_reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      bit_q     <= 5'd0;
      hi_q      <= 1'b0;
      rw_q      <= 1'b0;
      frame_q   <= 24'h0;
      rd_sh_q   <= 8'h00;
      sclk_q    <= 1'b0;
      csb_q     <= 1'b1;
      sdi_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      hi_q      <= hi_d;
      rw_q      <= rw_d;
      frame_q   <= frame_d;
      rd_sh_q   <= rd_sh_d;
      sclk_q    <= sclk_d;
      csb_q     <= csb_d;
      sdi_q     <= sdi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign o_spi_master_busy    = busy_q;
  assign o_spi_master_done    = done_q;
  assign o_spi_master_rd_data = rd_data_q;
  assign o_spi_master_sclk    = sclk_q;
  assign o_spi_master_csb_n   = csb_q;
  assign o_spi_master_sdi     = sdi_q;

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in system clocks, legal range 1..255.
REQ-002 SHALL have port i_spi_master_clk, input, 1: single system clock; all logic on its rising edge.
REQ-003 SHALL have port i_spi_master_reset_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port i_spi_master_start, input, 1: transaction request, sampled each clock.
REQ-005 SHALL have port i_spi_master_rw, input, 1: 1 = read, 0 = write; sampled with start.
REQ-006 SHALL have port i_spi_master_addr, input, 13: register address; sampled with start.
REQ-007 SHALL have port i_spi_master_wr_data, input, 8: write byte; sampled with start.
REQ-008 SHALL have port o_spi_master_busy, output, 1: transaction in progress.
REQ-009 SHALL have port o_spi_master_done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port o_spi_master_rd_data, output, 8: last byte read.
REQ-011 SHALL have port o_spi_master_sclk, output, 1: SPI clock to slave.
REQ-012 SHALL have port o_spi_master_csb_n, output, 1: SPI chip select, active low.
REQ-013 SHALL have port o_spi_master_sdi, output, 1: serial data to slave SDI.
REQ-014 SHALL have port i_spi_master_sdo, input, 1: serial data from slave SDO.

Function
REQ-015 SHALL accept start only in IDLE; accept cycle = cycle 0; start while busy SHALL be ignored, with no queuing.
REQ-016 SHALL latch a 24-bit frame at cycle 0: {rw, 2'b00, addr[12:0], wr_data[7:0]}, sent MSB first; for reads the data field SHALL be driven as 0.
REQ-017 SHALL use states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE, each timed by a clock-divider counter.
REQ-018 SETUP: csb_n SHALL go low at cycle 1 with sclk low and frame bit 23 on sdi, lasting CLK_DIV cycles.
REQ-019 SHIFT: 24 SCLK periods, each low for CLK_DIV then high for CLK_DIV cycles; sdi SHALL change only on sclk falling transitions, keeping mode 0 (idle low, slave samples on rising edge).
REQ-020 For reads, the master SHALL sample i_spi_master_sdo on the last system cycle of each sclk-high phase for bits 7..0, MSB first, into a shift register.
REQ-021 HOLD: after the 24th high phase, sclk SHALL be low with csb_n still low for CLK_DIV cycles.
REQ-022 GAP: csb_n SHALL be high and sclk low for CLK_DIV cycles; done SHALL pulse on the last GAP cycle, at cycle 51*CLK_DIV.
REQ-023 busy SHALL be high from cycle 1 through the done cycle inclusive; start SHALL be accepted again the cycle after done.
REQ-024 o_spi_master_rd_data SHALL update in the done cycle of read transactions only; writes SHALL leave it unchanged.
REQ-025 sclk, csb_n and sdi SHALL be registered outputs with no combinational glitches.
REQ-026 Exactly 24 rising sclk edges SHALL occur per transaction, all while csb_n is low.

Reset
REQ-027 Asserting reset SHALL immediately force: state IDLE, csb_n=1, sclk=0, sdi=0, busy=0, done=0, rd_data=0x00, counters 0.
REQ-028 Reset mid-transaction SHALL abort without a done pulse; the first start after release SHALL run a complete, normal transaction.

Verification
REQ-029 Write, CLK_DIV=4, addr 0x0006, data 0x02 -> sdi bits equal 0x000602 MSB first across 24 rising edges; done at cycle 204; busy cycles 1..204.
REQ-030 Read addr 0x0006; slave model drives 0xA5 on bits 16..23 -> rd_data=0xA5 at done; sdi=0 during the data field.
REQ-031 Start pulsed at cycles 0 and 50 -> only one transaction, 24 edges, one done pulse.
REQ-032 Reset asserted at cycle 100 of a write -> csb_n=1 and sclk=0 asynchronously; no done; next transaction correct.
REQ-033 CLK_DIV=1, back-to-back starts held high -> done at cycle 51; csb_n high for at least 1 cycle between frames; rd_data unchanged by writes.
